uart_rx: RTL and testbench

UART receiver: the receive-side counterpart of the team's 8N1 UART transmitter, running on the same 50 MHz system clock. It oversamples the asynchronous serial line, finds each start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. It presents each received byte with a one-cycle valid strobe, or a one-cycle framing-error strobe. It is also the reference receiver used to loop-check the transmitter in system benches.

---
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle for the 8N1 UART receiver: serial line in, byte and
// status strobes out. The slave modport is the receiver, the master the line/consumer.
`timescale 1ns/1ps

interface uart_rx_if;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output uart_rxd,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  rx_busy
  );

  modport slave (
    input  uart_rxd,
    output rx_data,
    output rx_valid,
    output frame_err,
    output rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the line, finds the start bit, samples
// each bit at mid-bit and checks the stop bit, emitting one-cycle strobes.
`timescale 1ns/1ps

module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic     clk_50M,
  input  logic     reset_n,
  uart_rx_if.slave bus
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             busy_q;
  logic             rxd_s;

  // NOTE: the raw line is asynchronous; only the second flop is safe to decide on.
  assign rxd_s = sync_q[1];

  // NOTE: every register here is updated with <= so all of them see the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.uart_rxd};
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxd_s) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == CNT_W'(HALF - 1)) begin
            cnt_q <= '0;
            if (rxd_s) begin
              // Line came back high before mid-start: a glitch, not a frame.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              bit_idx_q <= '0;
              state_q   <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (cnt_q == CNT_W'(CPB - 1)) begin
            cnt_q     <= '0;
            shift_q   <= {rxd_s, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (cnt_q == CNT_W'(CPB - 1)) begin
            cnt_q <= '0;
            if (rxd_s) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        BREAK: begin
          // Hold here until the line recovers so a long break reports once.
          if (rxd_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 115200 baud: single, back-to-back, glitch,
// framing error, reset mid-frame and +/-2% baud-skew frames.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int  CLK_FREQ = 50_000_000;
  localparam int  BAUD     = 115200;
  localparam int  CPB      = CLK_FREQ / BAUD;
  localparam int  HALF     = CPB / 2;
  localparam real BIT_NS   = 8681.0;

  logic clk;
  logic rst_n;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk_50M(clk),
    .reset_n(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks;
  int failures;

  int         cyc;
  int         valid_cnt;
  int         ferr_cnt;
  int         busy_cnt;
  int         excl_viol;
  int         width_viol;
  int         last_vcyc;
  logic [7:0] last_data;
  logic       v_d;
  logic       f_d;

  initial begin
    cyc = 0; valid_cnt = 0; ferr_cnt = 0; busy_cnt = 0;
    excl_viol = 0; width_viol = 0; last_vcyc = 0; last_data = 8'h00;
    v_d = 1'b0; f_d = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      last_data <= bus.rx_data;
      last_vcyc <= cyc;
    end
    if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
    if (bus.rx_busy) busy_cnt <= busy_cnt + 1;
    if (bus.rx_valid && bus.frame_err) excl_viol <= excl_viol + 1;
    if ((bus.rx_valid && v_d) || (bus.frame_err && f_d)) width_viol <= width_viol + 1;
    v_d <= bus.rx_valid;
    f_d <= bus.frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input real bit_ns);
    bus.uart_rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = b[i];
      #(bit_ns);
    end
    bus.uart_rxd = 1'b1;
    #(bit_ns);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int         v0, f0, b0, t1, diff;
  logic [7:0] rnd;
  real        bt;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n        = 1'b0;
    bus.uart_rxd = 1'b1;
    settle(3);
    check("reset_rx_data", bus.rx_data, 8'h00);
    check("reset_rx_valid", bus.rx_valid, 1'b0);
    check("reset_frame_err", bus.frame_err, 1'b0);
    check("reset_rx_busy", bus.rx_busy, 1'b0);
    rst_n = 1'b1;
    settle(20);

    // Single byte
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h12, BIT_NS);
    settle(5);
    check("single_valid_cnt", valid_cnt - v0, 1);
    check("single_data", last_data, 8'h12);
    check("single_no_ferr", ferr_cnt - f0, 0);
    check("single_busy_low", bus.rx_busy, 1'b0);

    // Back-to-back, no idle gap
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h34, BIT_NS);
    check("b2b_first_data", last_data, 8'h34);
    t1 = last_vcyc;
    send_byte(8'h56, BIT_NS);
    settle(5);
    check("b2b_second_data", last_data, 8'h56);
    check("b2b_valid_cnt", valid_cnt - v0, 2);
    check("b2b_no_ferr", ferr_cnt - f0, 0);
    diff = last_vcyc - t1;
    check("b2b_spacing", (diff >= 10 * CPB - 3 && diff <= 10 * CPB + 3), 1'b1);

    // Glitch shorter than half a bit
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    bus.uart_rxd = 1'b0;
    settle(100);
    bus.uart_rxd = 1'b1;
    settle(HALF + 4 - 100);
    check("glitch_busy_back_low", bus.rx_busy, 1'b0);
    check("glitch_busy_seen", (busy_cnt - b0) > 0, 1'b1);
    settle(CPB);
    check("glitch_no_valid", valid_cnt - v0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // Framing error: stop bit held low for three bit times
    v0 = valid_cnt; f0 = ferr_cnt;
    bus.uart_rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = (8'hA5 >> i) & 8'h01;
      #(BIT_NS);
    end
    bus.uart_rxd = 1'b0;
    #(3.0 * BIT_NS);
    bus.uart_rxd = 1'b1;
    #(BIT_NS);
    check("ferr_one_pulse", ferr_cnt - f0, 1);
    check("ferr_no_valid", valid_cnt - v0, 0);
    check("ferr_data_held", bus.rx_data, 8'h56);
    send_byte(8'h5A, BIT_NS);
    settle(5);
    check("after_ferr_data", last_data, 8'h5A);
    check("after_ferr_valid_cnt", valid_cnt - v0, 1);
    check("after_ferr_ferr_cnt", ferr_cnt - f0, 1);

    // Reset in the middle of data bit 4 of 8'hFF
    v0 = valid_cnt; f0 = ferr_cnt;
    bus.uart_rxd = 1'b0;
    #(BIT_NS);
    bus.uart_rxd = 1'b1;
    #(4.5 * BIT_NS);
    rst_n = 1'b0;
    settle(2);
    check("midrst_rx_data", bus.rx_data, 8'h00);
    check("midrst_rx_valid", bus.rx_valid, 1'b0);
    check("midrst_frame_err", bus.frame_err, 1'b0);
    check("midrst_rx_busy", bus.rx_busy, 1'b0);
    rst_n = 1'b1;
    #(4.5 * BIT_NS);
    check("midrst_no_valid", valid_cnt - v0, 0);
    check("midrst_no_ferr", ferr_cnt - f0, 0);
    send_byte(8'h3C, BIT_NS);
    settle(5);
    check("midrst_next_data", last_data, 8'h3C);
    check("midrst_next_valid_cnt", valid_cnt - v0, 1);
    check("midrst_next_ferr_cnt", ferr_cnt - f0, 0);

    // Random bytes at +2% / -2% bit time
    v0 = valid_cnt; f0 = ferr_cnt;
    for (int n = 0; n < 8; n++) begin
      rnd = 8'($urandom_range(0, 255));
      bt  = (n % 2 == 0) ? BIT_NS * 1.02 : BIT_NS * 0.98;
      send_byte(rnd, bt);
      settle(5);
      check($sformatf("skew_data_%0d", n), last_data, rnd);
      #(bt);
    end
    check("skew_valid_cnt", valid_cnt - v0, 8);
    check("skew_no_ferr", ferr_cnt - f0, 0);

    settle(5);
    check("strobe_exclusive", excl_viol, 0);
    check("strobe_one_cycle", width_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
